// File: rtl/soc_trace_monitor_pkg.sv
// soc_trace_monitor_pkg
// Shared constants and types for the multi-core trace monitor.
//   NOP_OPCODE / NOP_SUBOP : top two bytes that mark a special (magic) nop
//   CODE_EXIT / CODE_PUTC  : low 16 bits of a special nop selecting its action
//   mon_state_e            : global monitor FSM states
package soc_trace_monitor_pkg;

  localparam logic [7:0]  NOP_OPCODE = 8'h15;
  localparam logic [7:0]  NOP_SUBOP  = 8'h00;
  localparam logic [15:0] CODE_EXIT  = 16'h0001;
  localparam logic [15:0] CODE_PUTC  = 16'h0004;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } mon_state_e;

  // True when the instruction word is a special nop; its code is insn[15:0].
  function automatic logic is_special_nop(input logic [31:0] insn);
    return (insn[31:24] == NOP_OPCODE) && (insn[23:16] == NOP_SUBOP);
  endfunction

endpackage

// File: rtl/soc_trace_monitor_lane.sv
// soc_trace_monitor_lane
// Per-core trace tracking: special-nop decode, saturating retire counter,
// exit capture, one-entry putc character buffer and sticky overflow flag.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   valid_i         : retire strobe for this core
//   insn_i, r3_i    : retired instruction word and r3 value
//   pop_i           : the arbiter consumed this lane's buffered character
//   terminated_o    : EXIT has retired on this core
//   exit_code_o     : r3 captured at EXIT
//   insn_count_o    : retired instruction count (saturating)
//   overflow_o      : a character was dropped (sticky)
//   buf_full_o      : character buffer holds a character
//   buf_data_o      : buffered character
module soc_trace_monitor_lane
  import soc_trace_monitor_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [31:0]          insn_i,
  input  logic [31:0]          r3_i,
  input  logic                 pop_i,
  output logic                 terminated_o,
  output logic [31:0]          exit_code_o,
  output logic [CNT_WIDTH-1:0] insn_count_o,
  output logic                 overflow_o,
  output logic                 buf_full_o,
  output logic [7:0]           buf_data_o
);

  logic                 term_q, term_d;
  logic [31:0]          exit_q, exit_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 full_q, full_d;
  logic [7:0]           data_q, data_d;

  logic retire;
  logic special;
  logic is_exit;
  logic is_putc;

  // Decode the retiring instruction; a terminated core ignores all retires.
  always_comb begin
    retire  = valid_i & ~term_q;
    special = is_special_nop(insn_i);
    is_exit = retire & special & (insn_i[15:0] == CODE_EXIT);
    is_putc = retire & special & (insn_i[15:0] == CODE_PUTC);
  end

  // Next-state for counter, exit capture, character buffer and overflow.
  always_comb begin
    term_d = term_q;
    exit_d = exit_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    full_d = full_q;
    data_d = data_q;

    if (retire && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (is_exit) begin
      term_d = 1'b1;
      exit_d = r3_i;
    end else begin
      term_d = term_q;
      exit_d = exit_q;
    end

    if (pop_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end

    // A pop in the same cycle frees the slot, so the new char is accepted.
    if (is_putc) begin
      if (full_q && !pop_i) begin
        ovf_d = 1'b1;
      end else begin
        full_d = 1'b1;
        data_d = r3_i[7:0];
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      term_q <= 1'b0;
      exit_q <= 32'h0000_0000;
      cnt_q  <= {CNT_WIDTH{1'b0}};
      ovf_q  <= 1'b0;
      full_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      term_q <= term_d;
      exit_q <= exit_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign terminated_o = term_q;
  assign exit_code_o  = exit_q;
  assign insn_count_o = cnt_q;
  assign overflow_o   = ovf_q;
  assign buf_full_o   = full_q;
  assign buf_data_o   = data_q;

endmodule

// File: rtl/soc_multi_trace_monitor.sv
// soc_multi_trace_monitor
// Watches the retire traces of NUM_CORES cores, counts instructions, captures
// exit codes, and funnels putc characters into one round-robin arbitrated
// character stream. A global FSM reports completion or a watchdog timeout.
// Ports:
//   clk, rst                   : clock, synchronous active-low reset
//   trace_valid/insn/r3        : per-core retire traces (32-bit lanes packed)
//   char_valid/ready/data/core : putc character stream and its source core
//   terminated, exit_code      : per-core exit status
//   insn_count, overflow       : per-core counters and sticky drop flags
//   all_terminated, done, timeout : global status
module soc_multi_trace_monitor
  import soc_trace_monitor_pkg::*;
#(
  parameter  int NUM_CORES      = 4,
  parameter  int CNT_WIDTH      = 32,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int CORE_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CORES-1:0]           trace_valid,
  input  logic [NUM_CORES*32-1:0]        trace_insn,
  input  logic [NUM_CORES*32-1:0]        trace_r3,
  output logic                           char_valid,
  input  logic                           char_ready,
  output logic [7:0]                     char_data,
  output logic [CORE_W-1:0]              char_core,
  output logic [NUM_CORES-1:0]           terminated,
  output logic [NUM_CORES*32-1:0]        exit_code,
  output logic [NUM_CORES*CNT_WIDTH-1:0] insn_count,
  output logic [NUM_CORES-1:0]           overflow,
  output logic                           all_terminated,
  output logic                           done,
  output logic                           timeout
);

  localparam int             WD_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam bit             WD_EN    = (TIMEOUT_CYCLES > 0);

  mon_state_e        state_q, state_d;
  logic [CORE_W-1:0] ptr_q, ptr_d;
  logic              hold_q, hold_d;
  logic [CORE_W-1:0] hold_idx_q, hold_idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [NUM_CORES-1:0] buf_full;
  logic [7:0]           buf_data [NUM_CORES];
  logic [NUM_CORES-1:0] pop;
  logic                 any_full;
  logic                 all_term_raw;
  logic [CORE_W:0]      pick;
  logic [CORE_W-1:0]    sel;
  logic                 handshake;
  logic [CORE_W:0]      sel_inc;
  logic                 wd_expire;

  // First full buffer at or after ptr, returned as {found, index}. Scanning
  // from the far end lets the nearest full buffer overwrite the result last.
  function automatic logic [CORE_W:0] rr_pick(input logic [NUM_CORES-1:0] full,
                                              input logic [CORE_W-1:0]    ptr);
    logic [CORE_W:0] pos;
    logic [CORE_W:0] res;
    res = {(CORE_W+1){1'b0}};
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (CORE_W+1)'(k);
      if (pos >= (CORE_W+1)'(NUM_CORES)) begin
        pos = pos - (CORE_W+1)'(NUM_CORES);
      end else begin
        pos = pos;
      end
      if (full[pos[CORE_W-1:0]]) begin
        res = {1'b1, pos[CORE_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
    soc_trace_monitor_lane #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (trace_valid[g]),
      .insn_i       (trace_insn[g*32 +: 32]),
      .r3_i         (trace_r3[g*32 +: 32]),
      .pop_i        (pop[g]),
      .terminated_o (terminated[g]),
      .exit_code_o  (exit_code[g*32 +: 32]),
      .insn_count_o (insn_count[g*CNT_WIDTH +: CNT_WIDTH]),
      .overflow_o   (overflow[g]),
      .buf_full_o   (buf_full[g]),
      .buf_data_o   (buf_data[g])
    );
  end

  // Arbitration: once a character is presented and stalled, the selection is
  // frozen so a lower-index buffer filling later cannot change char_data.
  always_comb begin
    any_full     = |buf_full;
    all_term_raw = &terminated;
    pick         = rr_pick(buf_full, ptr_q);
    if (hold_q) begin
      sel = hold_idx_q;
    end else begin
      sel = pick[CORE_W-1:0];
    end
    char_valid = rst & any_full;
    handshake  = char_valid & char_ready;
    if (rst) begin
      char_data = buf_data[sel];
      char_core = sel;
    end else begin
      char_data = 8'h00;
      char_core = {CORE_W{1'b0}};
    end
    all_terminated = rst & all_term_raw;
    done           = rst & (state_q == ST_DONE);
    timeout        = rst & (state_q == ST_TIMEOUT);
  end

  // Pop strobe, pointer advance and stall-hold bookkeeping.
  always_comb begin
    pop        = {NUM_CORES{1'b0}};
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    hold_idx_d = hold_idx_q;
    sel_inc    = {1'b0, sel} + {{CORE_W{1'b0}}, 1'b1};
    if (handshake) begin
      pop[sel] = 1'b1;
      hold_d   = 1'b0;
      if (sel_inc >= (CORE_W+1)'(NUM_CORES)) begin
        ptr_d = {CORE_W{1'b0}};
      end else begin
        ptr_d = sel_inc[CORE_W-1:0];
      end
    end else if (char_valid) begin
      hold_d     = 1'b1;
      hold_idx_d = sel;
    end else begin
      hold_d = 1'b0;
    end
  end

  // Watchdog: any retire clears it; it only advances while RUN or DRAIN.
  always_comb begin
    wd_d = wd_q;
    if (|trace_valid) begin
      wd_d = {WD_W{1'b0}};
    end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (wd_q != WD_LIMIT)) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = wd_q;
    end
    wd_expire = WD_EN && (wd_d == WD_LIMIT);
  end

  // Global FSM next state; termination beats a simultaneous watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (all_term_raw) begin
          state_d = ST_DRAIN;
        end else if (wd_expire) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!any_full) begin
          state_d = ST_DONE;
        end else if (wd_expire) begin
          state_d = ST_TIMEOUT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE:    state_d = ST_DONE;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_RUN;
    endcase
  end

  // Global state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      ptr_q      <= {CORE_W{1'b0}};
      hold_q     <= 1'b0;
      hold_idx_q <= {CORE_W{1'b0}};
      wd_q       <= {WD_W{1'b0}};
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      wd_q       <= wd_d;
    end
  end

endmodule

// File: tb/tb_soc_multi_trace_monitor.sv
// Directed testbench for soc_multi_trace_monitor: one instance with default
// parameters (watchdog disabled) and one with TIMEOUT_CYCLES=10.
module tb_soc_multi_trace_monitor;

  localparam int N  = 4;
  localparam int CW = 32;

  localparam logic [31:0] I_PLAIN = 32'h0000_0013;
  localparam logic [31:0] I_EXIT  = 32'h1500_0001;
  localparam logic [31:0] I_PUTC  = 32'h1500_0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic              rst;
  logic [N-1:0]      trace_valid;
  logic [N*32-1:0]   trace_insn;
  logic [N*32-1:0]   trace_r3;
  logic              char_ready;
  logic              char_valid;
  logic [7:0]        char_data;
  logic [1:0]        char_core;
  logic [N-1:0]      terminated;
  logic [N*32-1:0]   exit_code;
  logic [N*CW-1:0]   insn_count;
  logic [N-1:0]      overflow;
  logic              all_terminated;
  logic              done;
  logic              timeout;

  // Watchdog instance signals
  logic              rst_w;
  logic [N-1:0]      tv_w;
  logic [N*32-1:0]   ti_w;
  logic [N*32-1:0]   tr_w;
  logic              cr_w;
  logic              cv_w;
  logic [7:0]        cd_w;
  logic [1:0]        cc_w;
  logic [N-1:0]      term_w;
  logic [N*32-1:0]   ec_w;
  logic [N*CW-1:0]   ic_w;
  logic [N-1:0]      ovf_w;
  logic              allt_w;
  logic              done_w;
  logic              to_w;

  int n_checks = 0;
  int n_errors = 0;

  soc_multi_trace_monitor #(
    .NUM_CORES(N), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(0)
  ) dut (
    .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_insn(trace_insn),
    .trace_r3(trace_r3), .char_valid(char_valid), .char_ready(char_ready),
    .char_data(char_data), .char_core(char_core), .terminated(terminated),
    .exit_code(exit_code), .insn_count(insn_count), .overflow(overflow),
    .all_terminated(all_terminated), .done(done), .timeout(timeout)
  );

  soc_multi_trace_monitor #(
    .NUM_CORES(N), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(10)
  ) dut_wd (
    .clk(clk), .rst(rst_w), .trace_valid(tv_w), .trace_insn(ti_w),
    .trace_r3(tr_w), .char_valid(cv_w), .char_ready(cr_w),
    .char_data(cd_w), .char_core(cc_w), .terminated(term_w),
    .exit_code(ec_w), .insn_count(ic_w), .overflow(ovf_w),
    .all_terminated(allt_w), .done(done_w), .timeout(to_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int c, input logic [31:0] insn, input logic [31:0] r3);
    trace_valid[c]        = 1'b1;
    trace_insn[c*32 +: 32] = insn;
    trace_r3[c*32 +: 32]   = r3;
  endtask

  task automatic idle();
    trace_valid = '0;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    char_ready = 1'b0;
    idle();
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got=expired expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b0; rst_w = 1'b0;
    trace_valid = '0; trace_insn = '0; trace_r3 = '0; char_ready = 1'b0;
    tv_w = '0; ti_w = '0; tr_w = '0; cr_w = 1'b0;
    step();

    // Outputs while reset is held
    check("rst_char_valid", char_valid, 0);
    check("rst_all_term",   all_terminated, 0);
    check("rst_done",       done, 0);
    check("rst_timeout",    timeout, 0);
    check("rst_terminated", terminated, 0);
    check("rst_count0",     insn_count[0 +: CW], 0);

    // Watchdog: limit 10, no retires after reset release
    rst_w = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("wd_before_limit", to_w, 0);
    step();
    check("wd_at_limit", to_w, 1);
    check("wd_done_low", done_w, 0);
    step(); step();
    check("wd_terminal", to_w, 1);

    // Core0: five plain instructions then EXIT with r3=0x2A
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drv(0, I_PLAIN, 32'h0);
      step();
    end
    check("c0_count5", insn_count[0 +: CW], 5);
    check("c0_not_term", terminated[0], 0);
    drv(0, I_EXIT, 32'h0000_002A);
    step();
    idle();
    check("c0_count6", insn_count[0 +: CW], 6);
    check("c0_exit_code", exit_code[0 +: 32], 32'h2A);
    check("c0_term", terminated[0], 1);
    drv(0, I_PLAIN, 32'h0);
    step();
    idle();
    check("c0_ignored_after_exit", insn_count[0 +: CW], 6);
    for (int i = 0; i < 20; i++) step();
    check("no_wd_when_disabled", timeout, 0);

    // Three simultaneous PUTCs drained in core order
    do_reset();
    char_ready = 1'b1;
    drv(0, I_PUTC, 32'h41);
    drv(1, I_PUTC, 32'h42);
    drv(2, I_PUTC, 32'h43);
    step();
    idle();
    check("rr_v0", char_valid, 1);
    check("rr_d0", char_data, 8'h41);
    check("rr_c0", char_core, 0);
    step();
    check("rr_d1", char_data, 8'h42);
    check("rr_c1", char_core, 1);
    step();
    check("rr_d2", char_data, 8'h43);
    check("rr_c2", char_core, 2);
    step();
    check("rr_empty", char_valid, 0);
    check("rr_no_ovf", overflow, 0);

    // Back-to-back PUTC on core1 while stalled: second char dropped
    do_reset();
    drv(1, I_PUTC, 32'h58);
    step();
    drv(1, I_PUTC, 32'h59);
    step();
    idle();
    check("ovf_flag", overflow[1], 1);
    check("ovf_held_data", char_data, 8'h58);
    check("ovf_held_core", char_core, 1);
    step();
    check("ovf_still_held", char_data, 8'h58);
    char_ready = 1'b1;
    step();
    char_ready = 1'b0;
    check("ovf_emitted_once", char_valid, 0);
    check("ovf_sticky", overflow[1], 1);

    // Stalled selection stays frozen; PUTC coinciding with pop is accepted
    do_reset();
    drv(2, I_PUTC, 32'h50);
    step();
    idle();
    drv(0, I_PUTC, 32'h52);
    step();
    idle();
    check("hold_core", char_core, 2);
    check("hold_data", char_data, 8'h50);
    char_ready = 1'b1;
    drv(2, I_PUTC, 32'h51);
    step();
    idle();
    check("pop_putc_no_ovf", overflow[2], 0);
    check("rr_after_wrap_core", char_core, 0);
    check("rr_after_wrap_data", char_data, 8'h52);
    step();
    check("pop_putc_core", char_core, 2);
    check("pop_putc_data", char_data, 8'h51);
    step();
    char_ready = 1'b0;
    check("pop_putc_empty", char_valid, 0);

    // All cores exit with core3's char pending: DRAIN until handshake
    do_reset();
    drv(3, I_PUTC, 32'h44);
    step();
    for (int c = 0; c < N; c++) drv(c, I_EXIT, 32'h10 + c);
    step();
    idle();
    check("drain_all_term", all_terminated, 1);
    check("drain_exit2", exit_code[2*32 +: 32], 32'h12);
    check("drain_core", char_core, 3);
    step(); step();
    check("drain_not_done", done, 0);
    char_ready = 1'b1;
    check("drain_data", char_data, 8'h44);
    step();
    char_ready = 1'b0;
    check("drain_done_lag", done, 0);
    check("drain_emptied", char_valid, 0);
    step();
    check("drain_done", done, 1);
    step();
    check("drain_done_hold", done, 1);

    // Reset during DRAIN with a pending char
    do_reset();
    drv(3, I_PUTC, 32'h45);
    step();
    for (int c = 0; c < N; c++) drv(c, I_EXIT, 32'h7);
    step();
    idle();
    step();
    check("abort_pending", char_valid, 1);
    rst = 1'b0;
    step();
    check("abort_char_valid", char_valid, 0);
    check("abort_all_term", all_terminated, 0);
    check("abort_terminated", terminated, 0);
    check("abort_exit_code", exit_code[3*32 +: 32], 0);
    check("abort_count", insn_count[3*CW +: CW], 0);
    rst = 1'b1;
    step();
    check("abort_run_valid", char_valid, 0);
    check("abort_run_done", done, 0);
    drv(0, I_PLAIN, 32'h0);
    step();
    idle();
    check("abort_counts_again", insn_count[0 +: CW], 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_multi_trace_monitor.md
SOC_MULTI_TRACE_MONITOR -- requirements
Module: soc_multi_trace_monitor

Interface
REQ-001 Parameter NUM_CORES, default 4: number of traced cores, 1..64.
REQ-002 Parameter CNT_WIDTH, default 32: per-core retired-instruction counter width.
REQ-003 Parameter TIMEOUT_CYCLES, default 0: watchdog limit in idle cycles; 0 disables the watchdog.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 trace_valid  in  NUM_CORES  per-core retire strobe.
REQ-008 trace_insn  in  NUM_CORES*32  retired instruction word, core i at [32i+31:32i].
REQ-009 trace_r3  in  NUM_CORES*32  r3 value at retire, same packing.
REQ-010 char_valid  out  1 / char_ready  in  1  putc stream handshake.
REQ-011 char_data  out  8 / char_core  out  $clog2(NUM_CORES) (min 1)  character and source core.
REQ-012 terminated  out  NUM_CORES  per-core exit seen.
REQ-013 exit_code  out  NUM_CORES*32  r3 captured at exit.
REQ-014 insn_count  out  NUM_CORES*CNT_WIDTH  retired instructions per core.
REQ-015 overflow  out  NUM_CORES  sticky putc-drop flag.
REQ-016 all_terminated  out  1 / done  out  1 / timeout  out  1  global status.

Function
REQ-017 Special nop: insn[31:24]==8'h15, insn[23:16]==0; code=insn[15:0]: 16'h0001 EXIT, 16'h0004 PUTC; other codes are plain instructions.
REQ-018 Retire on core i (trace_valid[i], terminated[i]==0): insn_count[i] +1 next cycle, saturating at all-ones.
REQ-019 EXIT retire: terminated[i] and exit_code[i]=r3 set next cycle; EXIT is itself counted; later retires on that core are ignored.
REQ-020 PUTC retire: r3[7:0] stored in core i's one-entry char buffer next cycle.
REQ-021 PUTC into a full buffer not popped that cycle: char dropped, overflow[i] set; PUTC in the same cycle as pop of that buffer: accepted, no overflow.
REQ-022 char_valid = OR of buffer-full flags; char_data/char_core driven from the round-robin winner, held stable while char_valid && !char_ready.
REQ-023 Round-robin pointer starts at 0; on handshake it moves to winner+1 (mod NUM_CORES); the winner is the first full buffer at/after the pointer.
REQ-024 all_terminated = AND of terminated, registered-state combinational.
REQ-025 Global FSM states RUN, DRAIN, DONE, TIMEOUT; reset -> RUN.
REQ-026 RUN -> DRAIN when all_terminated; DRAIN -> DONE when no buffer is full; DONE and TIMEOUT are terminal until reset.
REQ-027 done=1 only in DONE; timeout=1 only in TIMEOUT.
REQ-028 Watchdog (TIMEOUT_CYCLES>0): counter clears on any trace_valid, else increments in RUN/DRAIN; on reaching TIMEOUT_CYCLES -> TIMEOUT.
REQ-029 If the watchdog limit is reached in the same cycle as all_terminated rises, the RUN->DRAIN transition takes precedence.
REQ-030 Reset asserted mid-operation aborts everything; pending characters are discarded.

Reset
REQ-031 On rst==0 at a clock edge: all counters, exit_code, terminated, overflow, buffers, and RR pointer are 0; state is RUN.
REQ-032 During reset: char_valid, all_terminated, done, and timeout are 0.

Structure
REQ-033 Package soc_trace_monitor_pkg holds the NOP opcode/code constants and the FSM state enum.
REQ-034 The per-core logic (decode, counter, exit capture, char buffer, overflow) lives in sub-module soc_trace_monitor_lane, instantiated NUM_CORES times.

Verification
REQ-035 Core0 retires 5 plain insns then EXIT with r3=0x2A -> insn_count[0]=6, exit_code[0]=0x2A, terminated[0]=1 one cycle after the EXIT.
REQ-036 Cores 0,1,2 each PUTC 'A','B','C' in the same cycle, char_ready=1 -> chars out on three consecutive cycles in order 0,1,2, with no overflow.
REQ-037 Core1 issues two PUTCs back-to-back with char_ready=0 -> overflow[1]=1; the first char is held; on release, 'first' is emitted once.
REQ-038 All four cores EXIT while core3's buffer is full and char_ready=0 -> state stays DRAIN; done rises one cycle after the char handshake.
REQ-039 TIMEOUT_CYCLES=10, no trace_valid after reset -> timeout=1 after 10 cycles; done stays 0.
REQ-040 Reset pulled low during DRAIN with a pending char -> next cycle char_valid=0, all outputs 0, state RUN.
